// File: rtl/fp_div_pkg.sv
// Shared binary32 field widths, constants, operation/rounding encodings and the
// unpacked-operand record used by the fp_div divider.
package fp_div_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    // Quotient bits produced by the recurrence: 24 significand bits, guard and round.
    localparam int QBITS = MAN_W + 3;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam logic [31:0] MAX_FIN = 32'h7F7F_FFFF;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_RSV1 = 2'b01,
        OP_RSV2 = 2'b10,
        OP_RSV3 = 2'b11
    } op_e;

    typedef enum logic {
        RM_RNE = 1'b0,
        RM_RZ  = 1'b1
    } rmode_e;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
        logic             is_zero;
        logic             is_inf;
        logic             is_nan;
    } fp_unpacked_t;

    // Subnormals collapse to signed zero; the significand carries the hidden one.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x);
        fp_unpacked_t u;
        u.sign    = x[31];
        u.exp     = x[30:23];
        u.is_zero = (x[30:23] == '0);
        u.is_inf  = (x[30:23] == '1) && (x[22:0] == '0);
        u.is_nan  = (x[30:23] == '1) && (x[22:0] != '0);
        u.man     = u.is_zero ? '0 : {1'b1, x[22:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_div_if.sv
// Operand/result bundle for fp_div. With FPDIV_DONE_EN defined the bundle also
// carries the one-cycle done pulse.
interface fp_div_if;

    logic        round_mode;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
`ifdef FPDIV_DONE_EN
    logic        done;

    modport master (
        output round_mode, op, dividend, divisor,
        input  quotient, done
    );

    modport slave (
        input  round_mode, op, dividend, divisor,
        output quotient, done
    );
`else
    modport master (
        output round_mode, op, dividend, divisor,
        input  quotient
    );

    modport slave (
        input  round_mode, op, dividend, divisor,
        output quotient
    );
`endif

endinterface

// File: rtl/fp_div_ctrl.sv
// Free-running operation sequencer for fp_div: counts 0..PERIOD-1 and decodes
// the load, iterate and writeback strobes from the count.
module fp_div_ctrl
    import fp_div_pkg::*;
#(
    parameter int PERIOD = 28
) (
    input  logic clk,
    input  logic reset,
    output logic load_o,
    output logic iter_o,
    output logic wb_o
);

    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(PERIOD - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Cycles between the last iteration and PERIOD-1 are idle.
    assign load_o = (cnt_q == '0);
    assign iter_o = (cnt_q >= CNT_W'(1)) && (cnt_q <= CNT_W'(QBITS));
    assign wb_o   = (cnt_q == CNT_W'(PERIOD - 1));

endmodule

// File: rtl/fp_div.sv
// fp_div: iterative binary32 divider using a radix-2 non-restoring recurrence on a
// fixed PERIOD schedule. Optional macro FPDIV_DONE_EN adds the done pulse output.
module fp_div
    import fp_div_pkg::*;
#(
    parameter int PERIOD = 28
) (
    input  logic    clk,
    input  logic    reset,
    fp_div_if.slave bus
);

    localparam int E_W = EXP_W + 2;
    localparam int R_W = MAN_W + 4;

    localparam logic signed [E_W-1:0] EXP_OVF = E_W'(2 ** EXP_W - 1);
    localparam logic signed [E_W-1:0] EXP_ONE = E_W'(1);
    localparam logic signed [E_W-1:0] BIAS_E  = E_W'(BIAS);

    logic load;
    logic iter;
    logic wb;

    fp_unpacked_t a_u;
    fp_unpacked_t b_u;
    logic         sgn_d;
    logic         spec_d;
    logic [31:0]  spec_val_d;
    logic signed [E_W-1:0] exp_d;

    logic                  sign_q;
    logic signed [E_W-1:0] exp_q;
    logic                  rz_q;
    logic                  spec_q;
    logic [31:0]           spec_val_q;
    logic [MAN_W:0]        div_q;
    logic signed [R_W-1:0] rem_q;
    logic signed [R_W-1:0] rem_d;
    logic [QBITS-1:0]      qb_q;
    logic [QBITS-1:0]      qb_d;

    logic signed [R_W-1:0] div_ext;
    logic signed [R_W-1:0] trial;
    logic                  sticky;
    logic [31:0]           quotient_q;
    logic [31:0]           quotient_d;

    fp_div_ctrl #(.PERIOD(PERIOD)) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .load_o (load),
        .iter_o (iter),
        .wb_o   (wb)
    );

    // Normalise, round (RNE or RZ), then pack with overflow and FTZ handling.
    function automatic logic [31:0] round_pack(
        input logic                  sign,
        input logic signed [E_W-1:0] exp_in,
        input logic [QBITS-1:0]      qb,
        input logic                  stk,
        input logic                  rz
    );
        logic [MAN_W:0]        mant;
        logic [MAN_W+1:0]      msum;
        logic                  g;
        logic                  rb;
        logic                  inc;
        logic signed [E_W-1:0] e;
        if (qb[QBITS-1]) begin
            mant = qb[QBITS-1:2];
            g    = qb[1];
            rb   = qb[0];
            e    = exp_in;
        end else begin
            // Quotient below 1.0: the remainder still covers every discarded bit.
            mant = qb[QBITS-2:1];
            g    = qb[0];
            rb   = 1'b0;
            e    = exp_in - EXP_ONE;
        end
        inc  = ~rz & g & (rb | stk | mant[0]);
        msum = {1'b0, mant} + (MAN_W + 2)'(inc);
        if (msum[MAN_W+1]) begin
            mant = msum[MAN_W+1:1];
            e    = e + EXP_ONE;
        end else begin
            mant = msum[MAN_W:0];
        end
        if (e >= EXP_OVF) begin
            return rz ? {sign, MAX_FIN[30:0]} : {sign, POS_INF[30:0]};
        end else if (e < EXP_ONE) begin
            return {sign, 31'b0};
        end
        return {sign, e[EXP_W-1:0], mant[MAN_W-1:0]};
    endfunction

    // Load stage: unpack operands and resolve every special case up front.
    always_comb begin
        a_u        = fp_unpack(bus.dividend);
        b_u        = fp_unpack(bus.divisor);
        sgn_d      = a_u.sign ^ b_u.sign;
        exp_d      = $signed({2'b00, a_u.exp}) - $signed({2'b00, b_u.exp}) + BIAS_E;
        spec_d     = 1'b1;
        spec_val_d = QNAN;
        if (a_u.is_nan || b_u.is_nan || (op_e'(bus.op) != OP_DIV) ||
            (a_u.is_zero && b_u.is_zero) || (a_u.is_inf && b_u.is_inf)) begin
            spec_val_d = QNAN;
        end else if (a_u.is_inf || b_u.is_zero) begin
            spec_val_d = {sgn_d, POS_INF[30:0]};
        end else if (b_u.is_inf || a_u.is_zero) begin
            spec_val_d = {sgn_d, 31'b0};
        end else begin
            spec_d = 1'b0;
        end
    end

    // Iterate stage: one non-restoring step per cycle.
    always_comb begin
        div_ext = $signed({3'b000, div_q});
        trial   = rem_q[R_W-1] ? (rem_q + div_ext) : (rem_q - div_ext);
        rem_d   = trial <<< 1;
        qb_d    = {qb_q[QBITS-2:0], ~trial[R_W-1]};
        // rem_q holds twice the last partial remainder; a negative one is restored first.
        sticky  = rem_q[R_W-1] ? ((rem_q + (div_ext <<< 1)) != '0) : (rem_q != '0);
    end

    // Writeback stage.
    always_comb begin
        quotient_d = spec_q ? spec_val_q : round_pack(sign_q, exp_q, qb_q, sticky, rz_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rz_q       <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            div_q      <= '0;
            rem_q      <= '0;
            qb_q       <= '0;
            quotient_q <= '0;
        end else begin
            if (load) begin
                sign_q     <= sgn_d;
                exp_q      <= exp_d;
                rz_q       <= (rmode_e'(bus.round_mode) == RM_RZ);
                spec_q     <= spec_d;
                spec_val_q <= spec_val_d;
                div_q      <= b_u.man;
                rem_q      <= $signed({3'b000, a_u.man});
                qb_q       <= '0;
            end else if (iter) begin
                rem_q <= rem_d;
                qb_q  <= qb_d;
            end
            if (wb) begin
                quotient_q <= quotient_d;
            end
        end
    end

    assign bus.quotient = quotient_q;

`ifdef FPDIV_DONE_EN
    logic done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= wb;
        end
    end

    assign bus.done = done_q;
`endif

endmodule

// File: tb/tb_fp_div.sv
// Directed vector bench for fp_div: table-driven operations back to back on the
// PERIOD schedule, plus a reset-abort sequence.
module tb_fp_div;

    localparam int PERIOD = 28;
    localparam int NV     = 27;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        rm;
        logic [1:0]  op;
        logic [31:0] q;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    fp_div_if bus ();

    fp_div #(.PERIOD(PERIOD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] prev_q;
    vec_t        vt [NV];

`ifdef FPDIV_DONE_EN
    int done_total = 0;
    always @(negedge clk) if (bus.done === 1'b1) done_total++;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present operands just before a load edge; result lands after PERIOD edges.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic rm,
                         input logic [1:0] op, input logic [31:0] exp_q, input string name);
`ifdef FPDIV_DONE_EN
        int mark;
`endif
        bus.dividend   = a;
        bus.divisor    = b;
        bus.round_mode = rm;
        bus.op         = op;
        @(posedge clk);
        #1;
        bus.dividend   = $urandom();
        bus.divisor    = $urandom();
        bus.op         = 2'($urandom());
        bus.round_mode = 1'($urandom());
`ifdef FPDIV_DONE_EN
        mark = done_total;
`endif
        repeat (19) @(posedge clk);
        #1 check({name, "_hold"}, bus.quotient, prev_q);
        repeat (PERIOD - 20) @(posedge clk);
        #1 check(name, bus.quotient, exp_q);
`ifdef FPDIV_DONE_EN
        check({name, "_done"}, 32'(bus.done), 32'd1);
        check({name, "_dcnt"}, 32'(done_total - mark), 32'd0);
`endif
        prev_q = exp_q;
    endtask

    initial begin
        vt[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b00, 32'h3F00_0000};
        vt[1]  = '{32'h4040_0000, 32'h3F80_0000, 1'b0, 2'b00, 32'h4040_0000};
        vt[2]  = '{32'h3F80_0000, 32'h4040_0000, 1'b0, 2'b00, 32'h3EAA_AAAB};
        vt[3]  = '{32'h3F80_0000, 32'h4040_0000, 1'b1, 2'b00, 32'h3EAA_AAAA};
        vt[4]  = '{32'h3F80_0000, 32'h0000_0000, 1'b0, 2'b00, 32'h7F80_0000};
        vt[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 2'b00, 32'h7FC0_0000};
        vt[6]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b0, 2'b00, 32'h7FC0_0000};
        vt[7]  = '{32'hBF80_0000, 32'h7F80_0000, 1'b0, 2'b00, 32'h8000_0000};
        vt[8]  = '{32'h7F7F_FFFF, 32'h3E80_0000, 1'b0, 2'b00, 32'h7F80_0000};
        vt[9]  = '{32'h7F7F_FFFF, 32'h3E80_0000, 1'b1, 2'b00, 32'h7F7F_FFFF};
        vt[10] = '{32'h0080_0000, 32'h4000_0000, 1'b0, 2'b00, 32'h0000_0000};
        vt[11] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b01, 32'h7FC0_0000};
        vt[12] = '{32'hC0C0_0000, 32'h4000_0000, 1'b0, 2'b00, 32'hC040_0000};
        vt[13] = '{32'h40A0_0000, 32'h40E0_0000, 1'b0, 2'b00, 32'h3F36_DB6E};
        vt[14] = '{32'h40A0_0000, 32'h40E0_0000, 1'b1, 2'b00, 32'h3F36_DB6D};
        vt[15] = '{32'hBF80_0000, 32'h4040_0000, 1'b0, 2'b00, 32'hBEAA_AAAB};
        vt[16] = '{32'h7FC0_0000, 32'h3F80_0000, 1'b0, 2'b00, 32'h7FC0_0000};
        vt[17] = '{32'h7F80_0000, 32'hC000_0000, 1'b0, 2'b00, 32'hFF80_0000};
        vt[18] = '{32'h3F80_0000, 32'h8000_0000, 1'b0, 2'b00, 32'hFF80_0000};
        vt[19] = '{32'h8000_0000, 32'h3F80_0000, 1'b0, 2'b00, 32'h8000_0000};
        vt[20] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 2'b00, 32'h0000_0000};
        vt[21] = '{32'h0080_0000, 32'h3F80_0000, 1'b0, 2'b00, 32'h0080_0000};
        vt[22] = '{32'h3F80_0000, 32'h3F80_0001, 1'b0, 2'b00, 32'h3F7F_FFFE};
        vt[23] = '{32'h4B00_0000, 32'h3F00_0000, 1'b0, 2'b00, 32'h4B80_0000};
        vt[24] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b11, 32'h7FC0_0000};
        vt[25] = '{32'h7F80_0000, 32'h0000_0000, 1'b0, 2'b00, 32'h7F80_0000};
        vt[26] = '{32'hFF7F_FFFF, 32'h3E80_0000, 1'b1, 2'b00, 32'hFF7F_FFFF};

        reset          = 1'b1;
        bus.dividend   = 32'h4040_0000;
        bus.divisor    = 32'h3F80_0000;
        bus.round_mode = 1'b0;
        bus.op         = 2'b00;
        prev_q         = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1 check("reset_q", bus.quotient, 32'h0000_0000);
`ifdef FPDIV_DONE_EN
        check("reset_done", 32'(bus.done), 32'd0);
`endif
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            do_op(vt[i].a, vt[i].b, vt[i].rm, vt[i].op, vt[i].q, $sformatf("vec%0d", i));
        end

        // Abort an operation at cycle 10 with reset, then restart cleanly.
        do_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 2'b00, 32'h3F00_0000, "pre_abort");
        bus.dividend   = 32'h4040_0000;
        bus.divisor    = 32'h3F80_0000;
        bus.round_mode = 1'b0;
        bus.op         = 2'b00;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 check("abort_q", bus.quotient, 32'h0000_0000);
        repeat (2) @(posedge clk);
        #1 check("abort_hold_q", bus.quotient, 32'h0000_0000);
`ifdef FPDIV_DONE_EN
        check("abort_done", 32'(bus.done), 32'd0);
`endif
        reset  = 1'b0;
        prev_q = 32'h0000_0000;
        do_op(32'h4040_0000, 32'h3F80_0000, 1'b0, 2'b00, 32'h4040_0000, "after_abort");
        do_op(32'h3F80_0000, 32'h4040_0000, 1'b1, 2'b00, 32'h3EAA_AAAA, "after_abort2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fp_div.md
Name: fp_div

Overview:
- Iterative IEEE-754 binary32 divider. Computes quotient = dividend / divisor.
- Uses a radix-2 non-restoring mantissa recurrence driven by a free-running, fixed-period operation sequencer, so it needs no start/done handshake.
- Sits in the FP execute path. Consumers sample the inputs and the registered result on operation boundaries.

Parameters:
- PERIOD, 28, clock cycles per operation: 1 load + 26 iterate + 1 round/writeback. Legal range is 28 or more; extra cycles idle before writeback.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- round_mode  in  1  0 = round-to-nearest-even (RNE), 1 = round-toward-zero (RZ)
- op  in  2  operation code: 2'b00 = divide; any other value = invalid operation
- dividend  in  32  binary32 numerator
- divisor  in  32  binary32 denominator
- quotient  out  32  registered binary32 result of the last completed operation
- done  out  1  present only with FPDIV_DONE_EN (see Optional Feature)

Behaviour:
- Reset (sync, active-high): quotient = 32'h0000_0000, cycle counter = 0, datapath registers cleared. Reset asserted mid-operation aborts it; no writeback occurs.
- Counter runs 0..PERIOD-1 and wraps continuously after reset deasserts.
- Cycle 0 (load):
  - Latch dividend, divisor, op and round_mode.
  - Unpack fields, compute sign = sa^sb and exponent = ea - eb + 127.
  - Mantissas carry the implicit 1. Partial remainder = dividend mantissa.
- Cycles 1..26: one quotient bit per cycle by non-restoring division. This gives 24 bits, a guard bit and a round bit.
- The sticky bit is the OR of the final remainder being nonzero (remainder sign examined).
- If the mantissa quotient is below 1.0 (MSB = 0): shift left by 1 and decrement the exponent by 1.
- Last cycle: round, pack, register quotient. quotient holds stable for the whole next period.
- Inputs may change at any time; only values present at cycle 0 matter.
- RNE: increment when guard=1 and (round|sticky|lsb). RZ: truncate.
- A rounding carry out of the mantissa increments the exponent.
- Special cases, resolved at load and overriding the datapath result:
  - Either input NaN, 0/0, inf/inf, or op != 2'b00: output 32'h7FC0_0000 (canonical qNaN).
  - finite/0: ±inf.
  - inf/finite: ±inf.
  - finite/inf: ±0.
  - 0/nonzero finite: ±0.
- Subnormal inputs are treated as signed zero. Results below the normal range flush to signed zero (FTZ).
- Overflow (biased exponent ≥ 255 after rounding): ±inf in RNE, ±7F7F_FFFF in RZ.
- Sign of every zero and inf result = sa^sb.

Optional Feature:
- Macro FPDIV_DONE_EN.
- Defined: adds output port done, a 1-cycle pulse in the cycle after quotient updates. It is 0 during and out of reset, and never pulses after an aborted operation.
- Undefined: no done port; behaviour otherwise identical.

Decomposition:
- Package fp_div_pkg holds:
  - field widths (EXP_W = 8, MAN_W = 23), BIAS = 127
  - QNAN = 32'h7FC0_0000, POS_INF = 32'h7F80_0000, MAX_FIN = 32'h7F7F_FFFF
  - op and round-mode typedefs
  - an unpacked-float struct (sign, exp, man, is_zero, is_inf, is_nan)
- One natural sub-module: fp_div_ctrl. It holds the cycle counter and produces the load, iterate and writeback strobes.
- Recurrence, rounding and packing stay in fp_div.

Test Plan:
- RNE, 3F80_0000 / 4000_0000 (1/2) -> quotient 3F00_0000 one PERIOD after the load cycle; 4040_0000 / 3F80_0000 -> 4040_0000.
- Normalization path: 3F80_0000 / 4040_0000 (1/3) -> 3EAA_AAAB in RNE, 3EAA_AAAA in RZ (decrement-exponent path exercised).
- Specials: 3F80_0000 / 0000_0000 -> 7F80_0000; 0/0 -> 7FC0_0000; 7F80_0000 / 7F80_0000 -> 7FC0_0000; BF80_0000 / 7F80_0000 -> 8000_0000.
- Overflow/underflow: 7F7F_FFFF / 3E80_0000 -> 7F80_0000 in RNE, 7F7F_FFFF in RZ; 0080_0000 / 4000_0000 -> 0000_0000.
- Reset mid-operation at cycle 10 -> quotient = 0000_0000. The sequence restarts at cycle 0 after release, and the next result is correct.
- op = 2'b01 with normal operands -> 7FC0_0000. With FPDIV_DONE_EN, done pulses exactly once per PERIOD.
